// File: rtl/enc_pkg.sv
// Shared types and helpers for the multi-hot sequential encoder.
// The ENC_LAST_EN build macro adds the out_last port to multi_hot_encoder_seq.
package enc_pkg;

  typedef enum logic {ENC_IDLE, ENC_SCAN} enc_state_t;

  // Reference-model helper: index of the highest set bit, -1 when v is zero.
  function automatic int msb_index(input logic [63:0] v);
    msb_index = -1;
    for (int i = 0; i < 64; i++) begin
      if (v[i]) msb_index = i;
    end
  endfunction

endpackage

// File: rtl/multi_hot_encoder_seq_prio_index.sv
// Combinational highest-set-bit finder: idx is the MSB position of vec,
// any flags a non-zero vector (idx reads 0 when vec is zero).
module prio_index #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         any
);

  always_comb begin
    // NOTE: every output gets a default first so always_comb cannot infer a latch.
    idx = '0;
    any = |vec;
    // Ascending scan lets the highest set bit overwrite the lower ones.
    for (int i = 0; i < N; i++) begin
      if (vec[i]) idx = W'(i);
    end
  end

endmodule

// File: rtl/multi_hot_encoder_seq.sv
// Serialises an N-bit multi-hot vector into bit indices, highest first, with
// valid/ready on both sides. Define ENC_LAST_EN to add the out_last port.
module multi_hot_encoder_seq
  import enc_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_vec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx
`ifdef ENC_LAST_EN
  ,
  output logic         out_last
`endif
);

  enc_state_t   state;
  logic [N-1:0] pend;
  logic         pend_any;
  logic         last;
  logic         fire;

  prio_index #(.N(N)) u_prio_index (
    .vec (pend),
    .idx (out_idx),
    .any (pend_any)
  );

  // Exactly one bit left: clearing the lowest set bit leaves nothing behind.
  assign last      = pend_any && ((pend & (pend - 1'b1)) == '0);
  assign out_valid = (state == ENC_SCAN);
  assign fire      = out_valid && out_ready;
  assign in_ready  = (state == ENC_IDLE) || (fire && last);

`ifdef ENC_LAST_EN
  assign out_last = out_valid && last;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ENC_IDLE;
      pend  <= '0;
    end else begin
      // NOTE: non-blocking assignments so state and pend update together at the edge.
      case (state)
        ENC_IDLE: begin
          // A zero vector is accepted and dropped; nothing to emit.
          if (in_valid && (in_vec != '0)) begin
            pend  <= in_vec;
            state <= ENC_SCAN;
          end
        end
        ENC_SCAN: begin
          if (fire) begin
            if (last) begin
              // Final handshake doubles as an input slot for zero-bubble reload.
              if (in_valid && (in_vec != '0)) begin
                pend <= in_vec;
              end else begin
                pend  <= '0;
                state <= ENC_IDLE;
              end
            end else begin
              pend <= pend & ~(N'(1) << out_idx);
            end
          end
        end
        default: begin
          state <= ENC_IDLE;
          pend  <= '0;
        end
      endcase
    end
  end

endmodule
